// File: rtl/seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen
//
// Serialises a WIDTH-bit pattern MSB first, repeated a programmable number of
// times, with an optional early stop honoured at the next pattern boundary.
//
// Build option:
//   SEQ_GAP_EN  when defined, one idle cycle (out_o=0, out_valid_o=0,
//               busy_o=1) is inserted between consecutive repetitions.
//               Undefined (default): repetitions are contiguous.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      start request, honoured only in IDLE
//   pattern_i    pattern to serialise, captured on an accepted start
//   reps_i       repetition count, captured on an accepted start
//   stop_i       end after the pattern currently being sent
//   out_o        serial data (0 whenever out_valid_o is low)
//   out_valid_o  out_o carries a pattern bit
//   busy_o       controller is not idle
//   done_o       one-cycle completion pulse
//
// All outputs are registered from the current state, so they trail the
// state register by one cycle: the first bit is visible one cycle after the
// SHIFT state is entered, and done_o is visible the cycle after DONE.
//
// state | meaning
// IDLE  | waiting for start_i; stop latch held clear
// SHIFT | emitting one pattern bit per cycle
// GAP   | single spacer cycle between repetitions (SEQ_GAP_EN only)
// DONE  | single completion cycle, then back to IDLE
// ---------------------------------------------------------------------------
module seq_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [CNTW-1:0]  reps_i,
    input  logic             stop_i,
    output logic             out_o,
    output logic             out_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CNTW-1:0] ONE_REP  = CNTW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef SEQ_GAP_EN
        S_GAP   = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pat_q,   pat_d;
    logic [CNTW-1:0]  rem_q,   rem_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic             stop_q,  stop_d;
    logic             out_q,   out_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // A stop seen in the same cycle as the last bit counts as pending too.
    logic stop_pend;
    assign stop_pend = stop_q | stop_i;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = (state_q != S_IDLE);
        done_d  = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (start_i) begin
                    if (reps_i != '0) begin
                        shreg_d = pattern_i;
                        pat_d   = pattern_i;
                        rem_d   = reps_i;
                        bit_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_SHIFT: begin
                out_d   = shreg_q[WIDTH-1];
                valid_d = 1'b1;
                stop_d  = stop_pend;
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                bit_d   = bit_q + BW'(1);
                if (bit_q == LAST_BIT) begin
                    bit_d = '0;
                    if ((rem_q > ONE_REP) && !stop_pend) begin
                        rem_d   = rem_q - ONE_REP;
                        shreg_d = pat_q;
`ifdef SEQ_GAP_EN
                        state_d = S_GAP;
`else
                        state_d = S_SHIFT;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

`ifdef SEQ_GAP_EN
            // The next repetition was already committed when GAP was
            // entered, so a stop seen here is latched and ends the
            // transmission after that repetition; this keeps a gap from
            // ever trailing the final repetition.
            S_GAP: begin
                stop_d  = stop_pend;
                state_d = S_SHIFT;
            end
`endif

            S_DONE: begin
                stop_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            pat_q   <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// Testbench for seq_pattern_gen. Expected output per cycle is derived from
// the transmission rules: number of repetitions actually sent (after any
// stop), the slot each cycle falls into, and the pattern bit for that slot.
// ---------------------------------------------------------------------------
module tb_seq_pattern_gen;

    localparam int W  = 4;
    localparam int CW = 4;
`ifdef SEQ_GAP_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int P       = W + G;
    localparam int DET_EXP = (G == 1) ? 3 : 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [W-1:0]  pattern;
    logic [CW-1:0] reps;
    logic          out;
    logic          out_valid;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    seq_pattern_gen #(.WIDTH(W), .CNTW(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .pattern_i   (pattern),
        .reps_i      (reps),
        .stop_i      (stop),
        .out_o       (out),
        .out_valid_o (out_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit obs_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {busy, done, out_valid, out}
    function automatic logic [31:0] obs();
        return {28'd0, busy, done, out_valid, out};
    endfunction

    // Repetitions actually transmitted, given a stop seen in controller
    // cycle stop_j after the start edge (cycle 0 = first bit being produced).
    function automatic int sent_reps(input int r, input int stop_j);
        int full_t, rr, pos, n;
        if (r == 0) return 0;
        full_t = r * W + (r - 1) * G;
        if (stop_j < 0 || stop_j >= full_t) return r;
        rr  = stop_j / P;
        pos = stop_j % P;
        n   = (pos < W) ? rr + 1 : rr + 2;
        return (n < r) ? n : r;
    endfunction

    function automatic int count_1010();
        int c = 0;
        for (int i = 3; i < obs_q.size(); i++)
            if (obs_q[i-3] && !obs_q[i-2] && obs_q[i-1] && !obs_q[i]) c++;
        return c;
    endfunction

    // Called just after a rising edge. Drives start this cycle, then checks
    // every output cycle through the done pulse. With b2b set, returns in the
    // done cycle so the caller can issue the next start immediately.
    task automatic run_txn(input logic [W-1:0] pat, input int r, input int stop_j,
                           input bit junk, input bit b2b);
        int n, t, pos;
        logic [31:0] exp;
        n = sent_reps(r, stop_j);
        t = (n == 0) ? 0 : n * W + (n - 1) * G;
        obs_q.delete();
        start   = 1'b1;
        pattern = pat;
        reps    = CW'(r);
        stop    = junk ? 1'($urandom % 2) : 1'b0;
        @(posedge clk); #1;
        start = junk ? 1'($urandom % 2) : 1'b0;
        stop  = (stop_j == 0);
        if (junk) begin
            pattern = W'($urandom);
            reps    = CW'($urandom);
        end
        for (int i = 1; i <= t + 1; i++) begin
            @(posedge clk); #1;
            if (i <= t) begin
                pos = (i - 1) % P;
                if (pos < W) exp = {28'd0, 1'b1, 1'b0, 1'b1, pat[W-1-pos]};
                else         exp = 32'h8;
            end else begin
                exp = 32'hC;
            end
            chk($sformatf("txn r=%0d cyc%0d", r, i), obs(), exp);
            if (i <= t) obs_q.push_back(out);
            stop  = (i == stop_j);
            start = (junk && i <= t) ? 1'($urandom % 2) : 1'b0;
            if (junk) begin
                pattern = W'($urandom);
                reps    = CW'($urandom);
            end
        end
        if (!b2b) begin
            @(posedge clk); #1;
            chk("post_done_idle", obs(), 32'h0);
            stop = 1'b0;
        end
    endtask

    task automatic reset_mid(input logic [W-1:0] pat);
        start   = 1'b1;
        pattern = pat;
        reps    = CW'(3);
        stop    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_bit0", obs(), {28'd0, 1'b1, 1'b0, 1'b1, pat[W-1]});
        @(posedge clk); #1;
        chk("rstmid_bit1", obs(), {28'd0, 1'b1, 1'b0, 1'b1, pat[W-2]});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_cleared", obs(), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rstmid_no_done", obs(), 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, sj;
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        pattern = '0;
        reps    = '0;
        @(posedge clk); #1;
        chk("reset_state", obs(), 32'h0);
        start = 1'b1;
        reps  = CW'(2);
        pattern = 4'b1111;
        @(posedge clk); #1;
        chk("reset_over_start", obs(), 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", obs(), 32'h0);

        run_txn(4'b1010, 1, -1, 1'b0, 1'b0);

        run_txn(4'b1010, 3, -1, 1'b0, 1'b0);
        chk("det_1010", 32'(count_1010()), 32'(DET_EXP));
        chk("bits_seen", 32'(obs_q.size()), 32'(3 * W + 2 * G));

        run_txn(4'b1010, 5, P + 1, 1'b1, 1'b0);
        chk("stop_bits", 32'(obs_q.size()), 32'(2 * W + G));

        run_txn(4'b0110, 0, -1, 1'b0, 1'b0);

        reset_mid(4'b1101);
        run_txn(4'b1101, 2, -1, 1'b0, 1'b0);

        run_txn(4'b1001, 2, -1, 1'b0, 1'b1);
        run_txn(4'b0111, 1, -1, 1'b0, 1'b1);
        run_txn(4'b1110, 3, 2 * P - 1, 1'b0, 1'b0);

        run_txn(4'b1011, 4, 4 * W + 3 * G, 1'b1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            r  = int'($urandom_range(0, 15));
            sj = ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, r * P + 1));
            run_txn(W'($urandom), r, sj, 1'($urandom % 2), 1'($urandom % 2));
        end
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 4, pattern length in bits (minimum 2).
REQ-002 Parameter CNTW, default 4, width of the repetition count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 pattern  input  WIDTH  bit pattern to serialise, MSB first; captured on accepted start.
REQ-007 reps  input  CNTW  number of back-to-back pattern repetitions; captured on accepted start.
REQ-008 stop  input  1  request early termination at the next pattern boundary.
REQ-009 out  output  1  serial data bit, registered.
REQ-010 out_valid  output  1  high when out carries a pattern bit, registered.
REQ-011 busy  output  1  high in any state other than IDLE, registered.
REQ-012 done  output  1  one-cycle completion pulse, registered.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, GAP (present only with SEQ_GAP_EN) and DONE.
REQ-014 In IDLE with start=1 and reps!=0, the block SHALL capture pattern into a shift register and reps into a remaining-count register, then enter SHIFT.
REQ-015 In IDLE with start=1 and reps=0, the block SHALL enter DONE directly, without asserting out_valid.
REQ-016 Latency: for start sampled at edge k, the first bit (pattern[WIDTH-1]) SHALL appear on out with out_valid=1 after edge k+1.
REQ-017 In SHIFT, out SHALL present one bit per cycle, MSB first, with out_valid=1; a bit counter SHALL track position 0..WIDTH-1.
REQ-018 After bit WIDTH-1, if remaining>1 and no stop is pending, the block SHALL decrement remaining, reload the captured pattern, and continue (via GAP when enabled).
REQ-019 After bit WIDTH-1, if remaining=1 or a stop is pending, the block SHALL enter DONE.
REQ-020 Without gaps, repetitions SHALL be contiguous: out_valid is high for exactly WIDTH*reps consecutive cycles.
REQ-021 stop asserted in any SHIFT or GAP cycle SHALL be latched; the current pattern SHALL always complete in full, and no further repetition SHALL start.
REQ-022 stop in IDLE or DONE SHALL be ignored and SHALL NOT be latched.
REQ-023 start while busy=1 SHALL be ignored; pattern and reps changes while busy SHALL have no effect.
REQ-024 DONE SHALL last exactly one cycle with done=1, out_valid=0 and busy=1, then return to IDLE.
REQ-025 out SHALL be 0 whenever out_valid=0.
REQ-026 start accepted in the IDLE cycle immediately after DONE SHALL behave per REQ-014 and REQ-016 (back-to-back transmissions permitted).

Reset
REQ-027 rst=1 at a rising edge SHALL force state to IDLE and set out=0, out_valid=0, busy=0 and done=0, with the shift register, counters and stop latch cleared.
REQ-028 rst SHALL take priority over start and stop; reset mid-transmission SHALL abort with no done pulse.

Configuration
REQ-029 Macro SEQ_GAP_EN: when defined, the GAP state SHALL insert exactly one cycle (out=0, out_valid=0, busy=1) between consecutive repetitions; no gap follows the last repetition.
REQ-030 Without SEQ_GAP_EN, the GAP state and its logic SHALL be absent, and repetitions SHALL be contiguous per REQ-020.

Verification
REQ-031 rst high for 1 edge, then pattern=4'b1010, reps=1, start pulse -> out=1,0,1,0 on 4 valid cycles; done=1 in the 5th cycle; busy=0 in the 6th.
REQ-032 pattern=1010, reps=3, no gap -> 12 contiguous valid bits 101010101010; an overlapping 1010 detector fed this stream reports 5 detections.
REQ-033 Same stimulus with SEQ_GAP_EN -> valid bits 1010 _ 1010 _ 1010 with two single-cycle gaps; 14 busy cycles before DONE; the overlapping detector fed the stream (gap cycles as 0) reports 3 detections.
REQ-034 reps=5, stop pulsed during bit 1 of the 2nd repetition -> exactly 8 valid bits, then done; a start pulsed while busy is ignored.
REQ-035 reps=0 with start -> no valid bits, done=1 one cycle after the start edge.
REQ-036 rst asserted during the 2nd bit of a transmission -> all outputs 0 after that edge, no done pulse; the next start transmits normally from the MSB.
